fetch_stage: RTL



---
 rtl/fetch_stage_pkg.sv | 30 +++
 rtl/fetch_stage_queue.sv | 94 +++++++++
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants, state encoding and queue-entry layout for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int          PC_WIDTH    = 16;
    localparam int          INSTR_WIDTH = 16;
    localparam logic [15:0] NOP_INSTR   = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam logic [15:0] PC_STEP     = 16'h0002;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_WAIT   = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    npc;
        logic                   err;
    } fq_entry_t;

    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] instr);
        return (instr[15:11] == HALT_OPCODE);
    endfunction

    function automatic logic [PC_WIDTH-1:0] pc_incr(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_stage_queue.sv
// DEPTH-entry FIFO of fetched {instr, npc, err} entries sitting between the memory response and IF/ID.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  fq_entry_t              push_data_i,
    input  logic                   pop_i,
    output fq_entry_t              head_o,
    input  logic                   flush_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];

    // A flush wins over everything; a push into a full queue is only legal alongside a pop.
    assign do_pop_s  = pop_i & ~empty_o & ~flush_i;
    assign do_push_s = push_i & (~full_o | do_pop_s) & ~flush_i;

    // Next-state for pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, a single-outstanding imem handshake, the fetch queue and IF/ID.
module fetch_stage #(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 stall,
    input  logic                                 doBranch,
    input  logic [fetch_stage_pkg::PC_WIDTH-1:0] branchTarget,
    output logic                                 imemReq,
    output logic [fetch_stage_pkg::PC_WIDTH-1:0] imemAddr,
    input  logic                                 imemReady,
    input  logic                                 imemValid,
    input  logic [15:0]                          imemData,
    input  logic                                 imemErr,
    output logic [15:0]                          instrOut,
    output logic [fetch_stage_pkg::PC_WIDTH-1:0] nextPcOut,
    output logic                                 validOut,
    output logic                                 err
);

    import fetch_stage_pkg::*;

    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    fetch_state_e        state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] req_npc_q;
    logic                discard_q;
    logic                halt_pend_q;

    logic [15:0]         instr_q;
    logic [PC_WIDTH-1:0] npc_q;
    logic                valid_q;
    logic                err_q;

    logic                q_full_s;
    logic                q_empty_s;
    logic                q_push_s;
    logic                q_pop_s;
    logic                q_flush_s;
    logic [CNT_W-1:0]    q_count_s;
    fq_entry_t           q_head_s;
    fq_entry_t           q_push_data_s;

    logic                issue_s;
    logic                fire_s;
    logic                resp_s;
    logic                halt_pop_s;

    // imemReq is held low while rst is asserted even though state already reads RUN.
    assign issue_s       = rst & (state_q == ST_RUN) & (q_count_s < CNT_FULL) & ~doBranch;
    assign fire_s        = issue_s & imemReady;
    assign resp_s        = (state_q == ST_WAIT) & imemValid;
    assign q_flush_s     = doBranch;
    assign q_pop_s       = ~doBranch & ~stall & ~q_empty_s;
    assign halt_pop_s    = q_pop_s & is_halt(q_head_s.instr);
    assign q_push_s      = resp_s & ~discard_q & ~doBranch & (~q_full_s | q_pop_s);
    assign q_push_data_s = {imemData, req_npc_q, imemErr};

    assign imemReq       = issue_s;
    assign imemAddr      = pc_q;
    assign instrOut      = instr_q;
    assign nextPcOut     = npc_q;
    assign validOut      = valid_q;
    assign err           = err_q;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (q_push_s),
        .push_data_i (q_push_data_s),
        .pop_i       (q_pop_s),
        .head_o      (q_head_s),
        .flush_i     (q_flush_s),
        .full_o      (q_full_s),
        .empty_o     (q_empty_s),
        .count_o     (q_count_s)
    );

    // Fetch FSM: PC, outstanding-request bookkeeping, halt entry and redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            req_npc_q   <= RESET_PC;
            discard_q   <= 1'b0;
            halt_pend_q <= 1'b0;
        end else if (doBranch) begin
            pc_q        <= branchTarget;
            halt_pend_q <= 1'b0;
            // A response landing in the redirect cycle closes the request and is simply dropped.
            if ((state_q == ST_WAIT) && !imemValid) begin
                state_q   <= ST_WAIT;
                discard_q <= 1'b1;
            end else begin
                state_q   <= ST_RUN;
                discard_q <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (fire_s) begin
                        pc_q        <= pc_incr(pc_q);
                        req_npc_q   <= pc_incr(pc_q);
                        state_q     <= ST_WAIT;
                        halt_pend_q <= halt_pop_s;
                    end else if (halt_pop_s) begin
                        state_q <= ST_HALTED;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_WAIT: begin
                    // A halt seen while waiting takes effect once the in-flight response is absorbed.
                    if (imemValid) begin
                        discard_q   <= 1'b0;
                        halt_pend_q <= 1'b0;
                        state_q     <= (halt_pend_q | halt_pop_s) ? ST_HALTED : ST_RUN;
                    end else if (halt_pop_s) begin
                        halt_pend_q <= 1'b1;
                    end else begin
                        halt_pend_q <= halt_pend_q;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q     <= ST_RUN;
                    discard_q   <= 1'b0;
                    halt_pend_q <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID pipeline register feeding decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= NOP_INSTR;
            npc_q   <= {PC_WIDTH{1'b0}};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (doBranch) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (stall) begin
            instr_q <= instr_q;
            npc_q   <= npc_q;
            valid_q <= valid_q;
            err_q   <= err_q;
        end else if (!q_empty_s) begin
            instr_q <= q_head_s.instr;
            npc_q   <= q_head_s.npc;
            valid_q <= 1'b1;
            err_q   <= q_head_s.err;
        end else begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end
    end

endmodule
